// File: rtl/fifo_framer.sv
// fifo_framer: pulls payload words from an upstream FIFO read port and emits
// framed words on a valid/ready output stream.
//
// Frame layout:  header, FRAME_LEN payload words [, checksum trailer]
//   header = {zero-extend, SYNC_WORD[15:0], seq[7:0], FRAME_LEN[7:0]}
//
// Optional feature macro: FRAME_CHECKSUM_EN
//   defined   -> a trailer word (sum of payload mod 2^DATA_WIDTH) ends each
//                frame and carries m_last
//   undefined -> no trailer state or adder; m_last is on the last payload word
//
// Ports
//   rd_clk        in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   enable        in   allows a new frame to start from IDLE
//   read_req      out  pop request to the upstream FIFO
//   data_out      in   FIFO read data, valid one cycle after a pop
//   data_out_vld  in   FIFO read data valid
//   fifo_empty    in   FIFO empty flag
//   m_data        out  framed output word
//   m_valid       out  output word valid
//   m_ready       in   downstream accept
//   m_last        out  final word of a frame
//   frame_cnt     out  completed frames, wraps at 2^16
//   busy          out  state is not IDLE
//   dbg_state     out  raw FSM state (0 IDLE, 1 HDR, 2 DATA, 3 TRL)
//
// Output handshake: a word transfers on a rising edge where m_valid and
// m_ready are both 1; while m_valid=1 and m_ready=0 the word (m_data, m_last)
// is held unchanged until it transfers. The FIFO side pops on an edge where
// read_req=1 and fifo_empty=0, and the word returns with data_out_vld on the
// following cycle.

module fifo_framer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 8,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  read_req,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_out_vld,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frame_cnt,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
`ifdef FRAME_CHECKSUM_EN
    S_DATA = 2'd2,
    S_TRL  = 2'd3
`else
    S_DATA = 2'd2
`endif
  } state_e;

  localparam logic [7:0] FL8      = 8'(FRAME_LEN);
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  inflight_q;
  logic [7:0]            req_left_q, req_left_d;
  logic [7:0]            sent_q, sent_d;
  logic [7:0]            seq_q, seq_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
`ifdef FRAME_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic [DATA_WIDTH-1:0] hdr_word;
  logic [1:0]            free_slots;
  logic                  is_last;
  logic                  pop_buf;
  logic                  push_buf;
  logic                  frame_done;

  // Only words we actually asked for are accepted; this also drops a stale
  // data_out_vld that shows up right after reset.
  assign push_buf = data_out_vld & inflight_q;

  always_comb begin
    state_d     = state_q;
    req_left_d  = req_left_q;
    sent_d      = sent_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    pop_buf     = 1'b0;
    frame_done  = 1'b0;
    hdr_word    = '0;
    hdr_word[31:0] = {SYNC_WORD, seq_q, FL8};
    is_last     = (sent_q == LAST_IDX);
    free_slots  = 2'd2 - cnt_q;

    // A slot must be free for every pop already on its way back, so the
    // 2-entry buffer can never overflow whatever m_ready does.
    read_req = !fifo_empty && (state_q == S_HDR || state_q == S_DATA) &&
               (req_left_q != 8'd0) && (free_slots > {1'b0, inflight_q});

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_HDR;
          req_left_d = FL8;
          sent_d     = 8'd0;
`ifdef FRAME_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_word;
        if (m_ready) state_d = S_DATA;
      end
      S_DATA: begin
        m_valid = (cnt_q != 2'd0);
        m_data  = buf_q[rd_ptr_q];
`ifndef FRAME_CHECKSUM_EN
        m_last  = is_last & m_valid;
`endif
        if (m_valid && m_ready) begin
          pop_buf = 1'b1;
          sent_d  = sent_q + 8'd1;
`ifdef FRAME_CHECKSUM_EN
          csum_d  = csum_q + buf_q[rd_ptr_q];
`endif
          if (is_last) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = S_TRL;
`else
            state_d    = S_IDLE;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_TRL: begin
        m_valid = 1'b1;
        m_data  = csum_q;
        m_last  = 1'b1;
        if (m_ready) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (read_req) req_left_d = req_left_q - 8'd1;
    if (frame_done) begin
      seq_d       = seq_q + 8'd1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Outputs show reset values for the whole time rst is high, including
    // the first cycle before the registers have been cleared.
    if (rst) begin
      read_req = 1'b0;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_data   = '0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      inflight_q  <= 1'b0;
      req_left_q  <= 8'd0;
      sent_q      <= 8'd0;
      seq_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_left_q  <= req_left_d;
      sent_q      <= sent_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      inflight_q  <= read_req;
      if (push_buf) begin
        buf_q[wr_ptr_q] <= data_out;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_buf} - {1'b0, pop_buf};
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_framer.sv
// Testbench for fifo_framer (FRAME_LEN=4, DATA_WIDTH=32). Models the upstream
// FIFO with a queue, captures every output handshake, and compares frames
// against expected word lists built from the framing rules.
module tb_fifo_framer;

  localparam int FL = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int FW = FL + 2;
`else
  localparam int FW = FL + 1;
`endif

  logic        rd_clk = 1'b0;
  logic        rst, enable, read_req;
  logic [31:0] data_out;
  logic        data_out_vld, fifo_empty;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [15:0] frame_cnt;
  logic        busy;
  logic [1:0]  dbg_state;

  fifo_framer #(.DATA_WIDTH(32), .FRAME_LEN(FL), .SYNC_WORD(16'hA55A)) dut (
    .rd_clk(rd_clk), .rst(rst), .enable(enable), .read_req(read_req),
    .data_out(data_out), .data_out_vld(data_out_vld), .fifo_empty(fifo_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_cnt(frame_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 rd_clk = ~rd_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q[$];
  logic [32:0] got_q[$];   // {m_last, m_data}
  logic [32:0] exp_q[$];
  bit          hold_empty = 0;
  bit          rand_empty = 0;
  int          ready_mode = 0;  // 0 always ready, 1 toggle, 2 random
  bit          pend_vld = 0;
  int          occ = 0;
  int          hs_idx = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  int          exp_seq = 0;
  int          exp_frames = 0;

  typedef struct {
    logic [31:0] p0, p1, p2, p3;
    int          mode;
    logic [31:0] exp_hdr;
    logic [31:0] exp_sum;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[4];

  // ---------------- driver / monitor tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic refresh_empty();
    fifo_empty = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic cycle();
    bit do_pop;
    bit hs;
    @(negedge rd_clk);
    do_pop = read_req && !fifo_empty;
    if (fifo_empty) check("rreq_while_empty", 64'(read_req), 64'd0);
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (occ > 2) check("buf_overflow", 64'(occ), 64'd2);
      if (occ == 2) check("rreq_while_full", 64'(read_req), 64'd0);
    end
    hs = m_valid && m_ready;
    if (hs) begin
      got_q.push_back({m_last, m_data});
      if (hs_idx >= 1 && hs_idx <= FL) occ--;
      hs_idx = (hs_idx + 1) % FW;
    end
    if (data_out_vld && pend_vld) occ++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (rst) begin
      occ = 0; hs_idx = 0; prev_stall = 0;
    end
    @(posedge rd_clk);
    #1;
    if (do_pop) begin
      data_out = fifo_q.pop_front();
      data_out_vld = 1'b1;
      pend_vld = 1;
    end else begin
      data_out = $urandom;
      data_out_vld = 1'b0;
      pend_vld = 0;
    end
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (rand_empty) hold_empty = ($urandom_range(0, 3) == 0);
    refresh_empty();
  endtask

  task automatic load_fifo(input logic [31:0] p0, p1, p2, p3);
    fifo_q.push_back(p0); fifo_q.push_back(p1);
    fifo_q.push_back(p2); fifo_q.push_back(p3);
    refresh_empty();
  endtask

  task automatic push_expected(input logic [31:0] hdr, p0, p1, p2, p3, sum);
    exp_q.push_back({1'b0, hdr});
    exp_q.push_back({1'b0, p0});
    exp_q.push_back({1'b0, p1});
    exp_q.push_back({1'b0, p2});
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back({1'b0, p3});
    exp_q.push_back({1'b1, sum});
`else
    exp_q.push_back({1'b1, p3});
    if (^sum === 1'bx) $display("note: checksum value undefined");
`endif
  endtask

  // Reference model: header from the sync/seq/length rule, trailer as the
  // plain 32-bit sum of the payload.
  task automatic model_frame(input int seq, input logic [31:0] p0, p1, p2, p3);
    logic [31:0] hdr;
    logic [31:0] sum;
    hdr = {16'hA55A, 8'(seq), 8'(FL)};
    sum = p0 + p1 + p2 + p3;
    push_expected(hdr, p0, p1, p2, p3, sum);
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    if (got_q.size() < n) check({tag, "_timeout"}, 64'(got_q.size()), 64'(n));
  endtask

  task automatic compare_frames(input string tag, input int nframes);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_frames += nframes;
    exp_seq += nframes;
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_frames)));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic run_frame(input string tag);
    got_q.delete();
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_words(exp_q.size(), 400, tag);
    repeat (3) cycle();
    check({tag, "_idle"}, 64'(busy), 64'd0);
    compare_frames(tag, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{p0: 32'h1, p1: 32'h2, p2: 32'h3, p3: 32'h4, mode: 0,
               exp_hdr: 32'hA55A0004, exp_sum: 32'h0000000A, exp_cnt: 16'd1};
    tbl[1] = '{p0: 32'h10, p1: 32'h20, p2: 32'h30, p3: 32'h40, mode: 1,
               exp_hdr: 32'hA55A0104, exp_sum: 32'h000000A0, exp_cnt: 16'd2};
    tbl[2] = '{p0: 32'hFFFFFFFF, p1: 32'h1, p2: 32'h0, p3: 32'h2, mode: 0,
               exp_hdr: 32'hA55A0204, exp_sum: 32'h00000002, exp_cnt: 16'd3};
    tbl[3] = '{p0: 32'h12345678, p1: 32'h11111111, p2: 32'hEDCBA988, p3: 32'h0, mode: 2,
               exp_hdr: 32'hA55A0304, exp_sum: 32'h11111111, exp_cnt: 16'd4};

    rst = 1'b1; enable = 1'b0; m_ready = 1'b1;
    data_out = '0; data_out_vld = 1'b0;
    refresh_empty();
    repeat (3) cycle();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_read_req", 64'(read_req), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    repeat (2) cycle();
    check("idle_no_enable", 64'(busy), 64'd0);

    // table-driven frames
    for (int t = 0; t < 4; t++) begin
      ready_mode = tbl[t].mode;
      m_ready = 1'b1;
      load_fifo(tbl[t].p0, tbl[t].p1, tbl[t].p2, tbl[t].p3);
      push_expected(tbl[t].exp_hdr, tbl[t].p0, tbl[t].p1, tbl[t].p2, tbl[t].p3, tbl[t].exp_sum);
      run_frame($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_cnt_const", t), 64'(frame_cnt), 64'(tbl[t].exp_cnt));
    end
    ready_mode = 0; m_ready = 1'b1;

    // FIFO runs dry after payload word 2, refilled 20 cycles later
    push_expected(32'hA55A0404, 32'h7, 32'h8, 32'h9, 32'hA, 32'h22);
    fifo_q.push_back(32'h7); fifo_q.push_back(32'h8);
    refresh_empty();
    got_q.delete();
    enable = 1'b1; cycle(); enable = 1'b0;
    wait_words(3, 100, "gap_pre");
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("gap_m_valid", 64'(m_valid), 64'd0);
      check("gap_busy", 64'(busy), 64'd1);
    end
    fifo_q.push_back(32'h9); fifo_q.push_back(32'hA);
    refresh_empty();
    wait_words(FW, 100, "gap_post");
    repeat (2) cycle();
    compare_frames("gap", 1);

    // randomized frames against the model, ready toggled / random
    rand_empty = 1;
    for (int f = 0; f < 8; f++) begin
      logic [31:0] r0, r1, r2, r3;
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      ready_mode = (f % 2 == 0) ? 1 : 2;
      model_frame(exp_seq, r0, r1, r2, r3);
      load_fifo(r0, r1, r2, r3);
      run_frame($sformatf("rnd%0d", f));
    end
    rand_empty = 0; hold_empty = 0; ready_mode = 0; m_ready = 1'b1;
    refresh_empty();

    // back-to-back frames after reset; enable dropped during the third
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    exp_seq = 0; exp_frames = 0;
    for (int f = 0; f < 3; f++) begin
      logic [31:0] b0;
      b0 = 32'(16 * f);
      model_frame(f, b0 + 1, b0 + 2, b0 + 3, b0 + 4);
      load_fifo(b0 + 1, b0 + 2, b0 + 3, b0 + 4);
    end
    got_q.delete();
    enable = 1'b1;
    wait_words(2 * FW + 1, 200, "b2b_hdr3");
    enable = 1'b0;
    wait_words(3 * FW, 200, "b2b_end");
    repeat (30) cycle();
    check("b2b_no_frame4", 64'(busy), 64'd0);
    if (got_q.size() > 2 * FW)
      check("b2b_hdr2_const", 64'(got_q[2 * FW]), 64'({1'b0, 32'hA55A0204}));
    compare_frames("b2b", 3);

    // reset after payload word 3, stale data_out_vld right after release
    load_fifo(32'h1, 32'h2, 32'h3, 32'h4);
    got_q.delete();
    enable = 1'b1; cycle(); enable = 1'b0;
    wait_words(4, 100, "mrst_pre");
    rst = 1'b1;
    cycle();
    check("mrst_m_valid", 64'(m_valid), 64'd0);
    check("mrst_m_last", 64'(m_last), 64'd0);
    check("mrst_m_data", 64'(m_data), 64'd0);
    check("mrst_read_req", 64'(read_req), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    fifo_q.delete(); got_q.delete(); exp_q.delete();
    exp_seq = 0; exp_frames = 0;
    refresh_empty();
    data_out = 32'hDEADBEEF; data_out_vld = 1'b1; pend_vld = 0;
    cycle();
    cycle();
    check("mrst_idle", 64'(busy), 64'd0);
    model_frame(exp_seq, 32'h5, 32'h6, 32'h7, 32'h8);
    load_fifo(32'h5, 32'h6, 32'h7, 32'h8);
    got_q.delete();
    enable = 1'b1; cycle(); enable = 1'b0;
    wait_words(FW, 100, "mrst_post");
    repeat (2) cycle();
    if (got_q.size() > 0)
      check("mrst_hdr_const", 64'(got_q[0]), 64'({1'b0, 32'hA55A0004}));
    compare_frames("mrst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
